hazard_unit_mc: RTL

- Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Adds a multi-cycle execute handshake (MUL/DIV) with a busy FSM and a watchdog timeout, plus a parametrised register-address width.
- Keeps M/W forwarding, load-use stall and branch flush.
- Sits beside the datapath: stage-register enables are driven by Stall*, stage-register clears by Flush*.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_fwd_sel.sv | 31 +++
 rtl/hazard_unit_mc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the multi-cycle hazard unit.
//   - Forward select codes driven onto ForwardAE / ForwardBE.
//   - Multi-cycle execute FSM state encoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;   // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;   // operand from Writeback result
    localparam logic [1:0] FWD_MEM = 2'b10;   // operand from Memory ALU result

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mcState_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand forwarding priority select.
//   rsE        source register of the operand in Execute
//   rdM, rdW   destination registers in Memory / Writeback
//   regWriteM  Memory stage writes rdM
//   regWriteW  Writeback stage writes rdW
//   forward    FWD_MEM / FWD_WB / FWD_RF select (Memory has priority)
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    output logic [1:0]        forward
);

    // x0 is hardwired zero, so a write to it is never forwarded.
    always_comb begin
        forward = FWD_RF;
        if (rsE != '0) begin
            if (regWriteM && (rsE == rdM))
                forward = FWD_MEM;
            else if (regWriteW && (rsE == rdW))
                forward = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for the 5-stage RISC-V pipeline with a
// multi-cycle (MUL/DIV) execute handshake and watchdog abort.
//   clk, reset            clock, synchronous active-low reset
//   Rs1D/Rs2D             Decode sources (load-use detection)
//   Rs1E/Rs2E/RdE         Execute sources / destination
//   RdM/RdW, RegWriteM/W  forwarding producers
//   ResultSrcE0           load in Execute
//   PCSrcE                taken branch/jump in Execute
//   McStartE/McDoneE      multi-cycle op valid / result valid
//   StallF/D/E            stage-register holds
//   FlushD/E/M            stage-register clears
//   ForwardAE/BE          operand forward selects
//   McBusy                FSM in BUSY
//   McErr                 one-cycle pulse when the watchdog aborts an op
// Optional HAZARD_PERF_EN macro adds saturating counters StallCntO,
// FlushCntO and McCycCntO (CNT_W bits each).
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic              McDoneE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
    output logic              McErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  StallCntO,
    output logic [CNT_W-1:0]  FlushCntO,
    output logic [CNT_W-1:0]  McCycCntO
`endif
);

    // Count width covers the full MC_TIMEOUT range (up to 65535).
    localparam int              TO_W   = 16;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MC_TIMEOUT - 1);

    mcState_t        state, stateNext;
    logic [TO_W-1:0] toCnt, toCntNext;
    logic            abort;
    logic            lwStall, mcStall;
    logic [1:0]      fwdA, fwdB;

    hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
        .rsE(Rs1E), .rdM(RdM), .rdW(RdW),
        .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(fwdA)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
        .rsE(Rs2E), .rdM(RdM), .rdW(RdW),
        .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(fwdB)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            toCnt <= '0;
        end else begin
            state <= stateNext;
            toCnt <= toCntNext;
        end
    end

    // toCnt counts stall cycles of the current op, including the IDLE cycle
    // the op arrived in, so the abort lands on stall cycle MC_TIMEOUT.
    always_comb begin
        stateNext = state;
        toCntNext = toCnt;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (McStartE && !McDoneE) begin
                    stateNext = BUSY;
                    toCntNext = TO_W'(1);
                end
            end
            BUSY: begin
                if (McDoneE) begin
                    stateNext = IDLE;
                    toCntNext = '0;
                end else if (toCnt == TO_MAX) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                    toCntNext = '0;
                end else begin
                    toCntNext = toCnt + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                toCntNext = '0;
            end
        endcase
    end

    // Everything is gated by reset so the pipeline sees bubbles while held.
    assign lwStall = reset && ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign mcStall = reset && McStartE && !McDoneE && !abort;

    assign StallE    = mcStall;
    assign StallF    = lwStall || mcStall;
    assign StallD    = lwStall || mcStall;
    assign FlushM    = !reset || mcStall;
    // A stalled multi-cycle op keeps E occupied, so it masks E/D flushes.
    assign FlushE    = !reset || ((lwStall || PCSrcE) && !mcStall);
    assign FlushD    = !reset || (PCSrcE && !mcStall);
    assign ForwardAE = reset ? fwdA : FWD_RF;
    assign ForwardBE = reset ? fwdB : FWD_RF;
    assign McBusy    = reset && (state == BUSY);
    assign McErr     = reset && abort;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            StallCntO <= '0;
            FlushCntO <= '0;
            McCycCntO <= '0;
        end else begin
            if (StallF && (StallCntO != CNT_MAX)) StallCntO <= StallCntO + 1'b1;
            if (FlushE && (FlushCntO != CNT_MAX)) FlushCntO <= FlushCntO + 1'b1;
            if (mcStall && (McCycCntO != CNT_MAX)) McCycCntO <= McCycCntO + 1'b1;
        end
    end
`else
    // Counter width only matters when the perf counters are built.
    logic unusedCntW;
    assign unusedCntW = ^CNT_W;
`endif

`ifndef SYNTHESIS
    // Only one instruction can sit in E; a multi-cycle op and a taken branch
    // together means the decoder upstream is broken.
    always_ff @(posedge clk) begin
        if (reset)
            assert (!(McStartE && PCSrcE))
                else $warning("hazard_unit_mc: McStartE and PCSrcE asserted together");
    end
`endif

endmodule
